// File: rtl/jamma_input_scanner.sv
// JAMMA joystick splitter sequencer: drives JSELECT, samples the shared JJOY bus
// once per player bank after a settle time, and debounces player and coin bits.
module jamma_input_scanner #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter logic        SEL_P1_LEVEL   = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic [7:0] JJOY,
    input  logic [1:0] JCOIN,
    input  logic [5:0] LOCAL_JOY,
    output logic       JSELECT,
    output logic [7:0] JOY1,
    output logic [7:0] JOY2,
    output logic [1:0] COIN,
    output logic       SCAN_DONE
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] DB_THRESH   = 4'(DEBOUNCE_SCANS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE_P1,
        ST_SAMPLE_P1,
        ST_SETTLE_P2,
        ST_SAMPLE_P2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] settle_q, settle_d;
    logic       done_q, done_d;

    logic [7:0] joy1_q, joy1_d;
    logic [7:0] joy2_q, joy2_d;
    logic [1:0] coin_q, coin_d;
    logic [3:0] cnt1_q [8];
    logic [3:0] cnt1_d [8];
    logic [3:0] cnt2_q [8];
    logic [3:0] cnt2_d [8];
    logic [3:0] cntc_q [2];
    logic [3:0] cntc_d [2];

    logic [7:0] raw1;

    // On-board joystick shares the player-1 direction/button lines.
    assign raw1 = JJOY & {2'b11, LOCAL_JOY};

    // Returns {new_stable, new_count} for one bit on its sample cycle.
    function automatic logic [4:0] db_step(input logic raw, input logic stable,
                                           input logic [3:0] cnt);
        logic [3:0] inc;
        inc = cnt + 4'd1;
        if (raw == stable) begin
            return {stable, 4'd0};
        end else if (inc == DB_THRESH) begin
            return {raw, 4'd0};
        end else begin
            return {stable, inc};
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        done_d   = 1'b0;
        joy1_d   = joy1_q;
        joy2_d   = joy2_q;
        coin_d   = coin_q;
        cnt1_d   = cnt1_q;
        cnt2_d   = cnt2_q;
        cntc_d   = cntc_q;

        case (state_q)
            ST_IDLE: begin
                settle_d = '0;
                if (ENABLE) begin
                    state_d = ST_SETTLE_P1;
                end
            end

            ST_SETTLE_P1: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = ST_SAMPLE_P1;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end

            ST_SAMPLE_P1: begin
                for (int unsigned i = 0; i < 8; i++) begin
                    {joy1_d[i], cnt1_d[i]} = db_step(raw1[i], joy1_q[i], cnt1_q[i]);
                end
                for (int unsigned i = 0; i < 2; i++) begin
                    {coin_d[i], cntc_d[i]} = db_step(JCOIN[i], coin_q[i], cntc_q[i]);
                end
                settle_d = '0;
                state_d  = ST_SETTLE_P2;
            end

            ST_SETTLE_P2: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = ST_SAMPLE_P2;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end

            ST_SAMPLE_P2: begin
                for (int unsigned i = 0; i < 8; i++) begin
                    {joy2_d[i], cnt2_d[i]} = db_step(JJOY[i], joy2_q[i], cnt2_q[i]);
                end
                settle_d = '0;
                done_d   = 1'b1;
                state_d  = ENABLE ? ST_SETTLE_P1 : ST_IDLE;
            end

            default: begin
                settle_d = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            done_q   <= 1'b0;
            joy1_q   <= '1;
            joy2_q   <= '1;
            coin_q   <= '1;
            for (int unsigned i = 0; i < 8; i++) begin
                cnt1_q[i] <= '0;
                cnt2_q[i] <= '0;
            end
            for (int unsigned i = 0; i < 2; i++) begin
                cntc_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            done_q   <= done_d;
            joy1_q   <= joy1_d;
            joy2_q   <= joy2_d;
            coin_q   <= coin_d;
            cnt1_q   <= cnt1_d;
            cnt2_q   <= cnt2_d;
            cntc_q   <= cntc_d;
        end
    end

    // Bank select follows the state so it flips on the edge that ends each sample cycle.
    assign JSELECT   = (state_q == ST_SETTLE_P2 || state_q == ST_SAMPLE_P2)
                       ? ~SEL_P1_LEVEL : SEL_P1_LEVEL;
    assign JOY1      = joy1_q;
    assign JOY2      = joy2_q;
    assign COIN      = coin_q;
    assign SCAN_DONE = done_q;

endmodule

// File: tb/tb_jamma_input_scanner.sv
// Bench for jamma_input_scanner: scan-phase reference model checked every cycle,
// a vector table of held patterns, hand sequences for corner cases, random soak.
module tb_jamma_input_scanner;

    localparam int S = 4;
    localparam int N = 3;

    logic       CLK;
    logic       RESET;
    logic       ENABLE;
    logic [7:0] JJOY;
    logic [1:0] JCOIN;
    logic [5:0] LOCAL_JOY;
    logic       JSELECT;
    logic [7:0] JOY1;
    logic [7:0] JOY2;
    logic [1:0] COIN;
    logic       SCAN_DONE;

    jamma_input_scanner #(
        .SETTLE_CYCLES (S),
        .DEBOUNCE_SCANS(N),
        .SEL_P1_LEVEL  (1'b0)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENABLE   (ENABLE),
        .JJOY     (JJOY),
        .JCOIN    (JCOIN),
        .LOCAL_JOY(LOCAL_JOY),
        .JSELECT  (JSELECT),
        .JOY1     (JOY1),
        .JOY2     (JOY2),
        .COIN     (COIN),
        .SCAN_DONE(SCAN_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int nchecks = 0;
    int nfail   = 0;

    // External splitter: the bank values it presents on JJOY
    logic [7:0] p1_val;
    logic [7:0] p2_val;

    // Reference model: position within a scan period plus per-bit debounce counts
    bit         m_act;
    int         m_t;
    logic [7:0] m_j1, m_j2;
    logic [1:0] m_c;
    logic       m_done;
    int         c1[8];
    int         c2[8];
    int         cc[2];

    typedef struct {
        logic [7:0] p1;
        logic [7:0] p2;
        logic [5:0] loc;
        logic [1:0] coin;
        int         scans;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [1:0] ec;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic db(input logic raw, input logic st_in, input int c_in,
                      output logic st_out, output int c_out);
        st_out = st_in;
        c_out  = 0;
        if (raw != st_in) begin
            c_out = c_in + 1;
            if (c_out >= N) begin
                st_out = raw;
                c_out  = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_act  = 0;
        m_t    = 0;
        m_j1   = 8'hFF;
        m_j2   = 8'hFF;
        m_c    = 2'b11;
        m_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            c1[i] = 0;
            c2[i] = 0;
        end
        cc[0] = 0;
        cc[1] = 0;
    endtask

    task automatic model_edge();
        logic [7:0] raw;
        logic       st;
        int         c;
        if (RESET) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            if (!m_act) begin
                if (ENABLE) begin
                    m_act = 1;
                    m_t   = 0;
                end
            end else if (m_t == S) begin
                raw = JJOY & {2'b11, LOCAL_JOY};
                for (int i = 0; i < 8; i++) begin
                    db(raw[i], m_j1[i], c1[i], st, c);
                    m_j1[i] = st;
                    c1[i]   = c;
                end
                for (int i = 0; i < 2; i++) begin
                    db(JCOIN[i], m_c[i], cc[i], st, c);
                    m_c[i] = st;
                    cc[i]  = c;
                end
                m_t++;
            end else if (m_t == 2 * S + 1) begin
                raw = JJOY;
                for (int i = 0; i < 8; i++) begin
                    db(raw[i], m_j2[i], c2[i], st, c);
                    m_j2[i] = st;
                    c2[i]   = c;
                end
                m_done = 1'b1;
                if (ENABLE) m_t = 0;
                else m_act = 0;
            end else begin
                m_t++;
            end
        end
    endtask

    task automatic step();
        logic exp_sel;
        JJOY = JSELECT ? p2_val : p1_val;
        @(posedge CLK);
        model_edge();
        #1;
        exp_sel = (m_act && m_t > S) ? 1'b1 : 1'b0;
        chk("cycle {sel,joy1,joy2,coin,done}",
            32'({JSELECT, JOY1, JOY2, COIN, SCAN_DONE}),
            32'({exp_sel, m_j1, m_j2, m_c, m_done}));
    endtask

    // Advance until the model is in the settle phase of bank 2; bounded.
    task automatic goto_settle_p2();
        int guard;
        guard = 0;
        while (!(m_act && m_t == S + 2) && guard < 30) begin
            step();
            guard++;
        end
        chk("reach_settle_p2", 32'(m_act && m_t == S + 2), 32'd1);
    endtask

    initial begin
        int pulses;
        bit bad_leak;

        tbl[0] = '{p1: 8'hFE, p2: 8'h7F, loc: 6'h3F, coin: 2'b11, scans: 3, e1: 8'hFE, e2: 8'h7F, ec: 2'b11};
        tbl[1] = '{p1: 8'hFF, p2: 8'hFF, loc: 6'b111011, coin: 2'b10, scans: 3, e1: 8'hFB, e2: 8'hFF, ec: 2'b10};
        tbl[2] = '{p1: 8'hFF, p2: 8'hFF, loc: 6'h3F, coin: 2'b11, scans: 2, e1: 8'hFB, e2: 8'hFF, ec: 2'b10};
        tbl[3] = '{p1: 8'hFF, p2: 8'hFF, loc: 6'h3F, coin: 2'b11, scans: 1, e1: 8'hFF, e2: 8'hFF, ec: 2'b11};
        tbl[4] = '{p1: 8'h5A, p2: 8'hA5, loc: 6'h3F, coin: 2'b01, scans: 3, e1: 8'h5A, e2: 8'hA5, ec: 2'b01};
        tbl[5] = '{p1: 8'hC3, p2: 8'h3C, loc: 6'b110000, coin: 2'b11, scans: 3, e1: 8'hC0, e2: 8'h3C, ec: 2'b11};

        model_reset();
        RESET     = 1'b1;
        ENABLE    = 1'b0;
        JCOIN     = 2'b11;
        LOCAL_JOY = 6'h3F;
        p1_val    = 8'hFF;
        p2_val    = 8'hFF;
        JJOY      = 8'hFF;

        // Reset state
        repeat (3) step();
        chk("rst_joy1", 32'(JOY1), 32'hFF);
        chk("rst_joy2", 32'(JOY2), 32'hFF);
        chk("rst_coin", 32'(COIN), 32'h3);
        chk("rst_jselect", 32'(JSELECT), 32'h0);
        chk("rst_scan_done", 32'(SCAN_DONE), 32'h0);

        // Scan timing and P1 bit0 bounce; edge k=1 leaves IDLE, P1 sampled at edge 10w+6
        ENABLE = 1'b1;
        step();
        RESET = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            int w;
            w = (k - 1) / 10;
            p1_val = (w == 2) ? 8'hFF : 8'hFE;
            step();
            chk("sel_timing", 32'(JSELECT), 32'(((k - 1) % 10) >= 5));
            chk("done_timing", 32'(SCAN_DONE), 32'(k >= 11 && ((k - 1) % 10) == 0));
            if (k == 30) chk("bounce_hold", 32'(JOY1), 32'hFF);
            if (k == 55) chk("bounce_pre", 32'(JOY1), 32'hFF);
            if (k == 56) chk("bounce_accept", 32'(JOY1), 32'hFE);
        end

        // Held patterns from the vector table
        for (int r = 0; r < 6; r++) begin
            p1_val    = tbl[r].p1;
            p2_val    = tbl[r].p2;
            LOCAL_JOY = tbl[r].loc;
            JCOIN     = tbl[r].coin;
            bad_leak  = 0;
            for (int k = 0; k < tbl[r].scans * 2 * (S + 1); k++) begin
                step();
                if (r == 0 && (JOY1 == 8'h7F || JOY2 == 8'hFE)) bad_leak = 1;
            end
            chk($sformatf("tbl%0d_joy1", r), 32'(JOY1), 32'(tbl[r].e1));
            chk($sformatf("tbl%0d_joy2", r), 32'(JOY2), 32'(tbl[r].e2));
            chk($sformatf("tbl%0d_coin", r), 32'(COIN), 32'(tbl[r].ec));
            if (r == 0) chk("bank_leak", 32'(bad_leak), 32'd0);
        end

        // ENABLE dropped during bank-2 settle: scan completes, one pulse, then idle
        goto_settle_p2();
        ENABLE = 1'b0;
        pulses = 0;
        repeat (20) begin
            step();
            if (SCAN_DONE === 1'b1) pulses++;
        end
        chk("disable_pulses", 32'(pulses), 32'd1);
        chk("disable_jselect", 32'(JSELECT), 32'h0);
        chk("disable_joy1_held", 32'(JOY1), 32'hC0);
        chk("disable_joy2_held", 32'(JOY2), 32'h3C);

        // Reset during bank-2 settle with JOY1=FE
        p1_val    = 8'hFE;
        p2_val    = 8'hFF;
        LOCAL_JOY = 6'h3F;
        ENABLE    = 1'b1;
        repeat (32) step();
        chk("pre_reset_joy1", 32'(JOY1), 32'hFE);
        goto_settle_p2();
        RESET = 1'b1;
        step();
        chk("midreset_jselect", 32'(JSELECT), 32'h0);
        chk("midreset_joy1", 32'(JOY1), 32'hFF);
        chk("midreset_done", 32'(SCAN_DONE), 32'h0);
        RESET  = 1'b0;
        ENABLE = 1'b0;
        pulses = 0;
        repeat (15) begin
            step();
            if (SCAN_DONE === 1'b1) pulses++;
        end
        chk("midreset_no_pulse", 32'(pulses), 32'd0);

        // Random soak against the model
        ENABLE = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(19) == 0) p1_val = 8'($urandom());
            if ($urandom_range(19) == 0) p2_val = 8'($urandom());
            if ($urandom_range(9) == 0) p1_val[$urandom_range(7)] ^= 1'b1;
            if ($urandom_range(9) == 0) p2_val[$urandom_range(7)] ^= 1'b1;
            if ($urandom_range(29) == 0) LOCAL_JOY = 6'($urandom());
            if ($urandom_range(29) == 0) JCOIN = 2'($urandom());
            ENABLE = ($urandom_range(99) < 93);
            RESET  = ($urandom_range(499) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
